// File: rtl/fir_input_feeder.sv
// Purpose: buffers host sample/coefficient words and replays them to the FIR controller as data_ready/load_coeff strobes.
// Latency: a word is poppable one cycle after push; its strobe is high for the 2 cycles after the pop; issues are at least 5 cycles apart.
// Backpressure: in_ready drops when the FIFO is full (and during an error flush with FEEDER_FLUSH_ON_ERR_EN); issue stalls while modwait is high.
module fir_input_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   in_valid,
  input  logic                   in_is_coeff,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic                   modwait,
  input  logic                   err,
  output logic                   data_ready,
  output logic                   load_coeff,
  output logic [DATA_W-1:0]      sample_data,
  output logic [DATA_W-1:0]      fir_coefficient,
  output logic [1:0]             coeff_idx,
  output logic [15:0]            sample_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    PULSE2,
    GUARD,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic              is_coeff;
    logic [DATA_W-1:0] dat;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  state_t           state_nxt;
  logic             issue_is_coeff;
  logic             push;
  logic             pop;
  logic             flush;

  assign head     = mem[rd_ptr];
  assign in_ready = (fifo_count != FULL_CNT) && !flush;
  assign push     = in_valid && in_ready;

  // Next state, pop request and strobes; the strobe type follows the word latched at pop time.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    flush      = 1'b0;
    data_ready = 1'b0;
    load_coeff = 1'b0;
    case (state)
      IDLE: begin
        // fifo_count is registered, so a word pushed this edge cannot be popped until the next one.
        if ((fifo_count != '0) && !modwait) begin
          pop       = 1'b1;
          state_nxt = PULSE1;
        end
      end
      PULSE1: begin
        data_ready = !issue_is_coeff;
        load_coeff = issue_is_coeff;
        state_nxt  = PULSE2;
      end
      PULSE2: begin
        data_ready = !issue_is_coeff;
        load_coeff = issue_is_coeff;
        state_nxt  = GUARD;
      end
      // Quiet cycle so the controller's registered modwait has time to rise.
      GUARD: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!modwait) begin
          state_nxt = IDLE;
`ifdef FEEDER_FLUSH_ON_ERR_EN
          flush = err;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef FEEDER_FLUSH_ON_ERR_EN
  // Without the flush option the controller error flag has no effect here.
  logic unused_err;
  assign unused_err = err;
`endif

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!n_reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_is_coeff, in_data};
  end

  // Issue registers: each output word holds until the next pop of its own kind.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      issue_is_coeff  <= 1'b0;
      sample_data     <= '0;
      fir_coefficient <= '0;
      coeff_idx       <= 2'd0;
      sample_cnt      <= 16'd0;
    end else if (pop) begin
      issue_is_coeff <= head.is_coeff;
      if (head.is_coeff) begin
        fir_coefficient <= head.dat;
        coeff_idx       <= coeff_idx + 2'd1;
      end else begin
        sample_data <= head.dat;
        sample_cnt  <= sample_cnt + 16'd1;
      end
    end else if (flush) begin
      coeff_idx <= 2'd0;
    end
  end

endmodule

// File: tb/tb_fir_input_feeder.sv
// Bench for fir_input_feeder: directed steps plus a random phase, checked every cycle against a queue-based model.
// The model tracks the issue timeline as "cycles since pop" and the FIFO as a plain queue of pushed words.
// Define FEEDER_FLUSH_ON_ERR_EN for both files to exercise the error-flush option.
module tb_fir_input_feeder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic        in_is_coeff;
  logic [15:0] in_data;
  logic        in_ready;
  logic        modwait;
  logic        err;
  logic        data_ready;
  logic        load_coeff;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic [1:0]  coeff_idx;
  logic [15:0] sample_cnt;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  fir_input_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .in_valid       (in_valid),
    .in_is_coeff    (in_is_coeff),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .modwait        (modwait),
    .err            (err),
    .data_ready     (data_ready),
    .load_coeff     (load_coeff),
    .sample_data    (sample_data),
    .fir_coefficient(fir_coefficient),
    .coeff_idx      (coeff_idx),
    .sample_cnt     (sample_cnt),
    .fifo_count     (fifo_count)
  );

  typedef struct {
    bit          c;
    logic [15:0] d;
  } word_t;

  // Reference model state.
  word_t       q[$];
  word_t       cur;
  int          age;            // 0: waiting to issue; 1,2: strobe; 3: guard; >=4: waiting on modwait
  int          n_coeff_pops;
  int          n_sample_pops;
  logic [15:0] m_samp;
  logic [15:0] m_coef;
  bit          armed = 1'b0;
  bit          last_push;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    age           = 0;
    n_coeff_pops  = 0;
    n_sample_pops = 0;
    m_samp        = 16'h0;
    m_coef        = 16'h0;
    cur.c         = 1'b0;
    cur.d         = 16'h0;
  endtask

  // One clock: check in_ready before the edge, advance the model across the edge, then check all outputs.
  task automatic tick();
    bit    rst, push, flush, mw;
    word_t w, inw;
    #1;
    rst   = !n_reset;
    mw    = modwait;
    flush = 1'b0;
`ifdef FEEDER_FLUSH_ON_ERR_EN
    flush = (age >= 4) && err && !mw;
`endif
    if (armed) chk("in_ready", in_ready, (q.size() != DEPTH) && !flush);
    push  = in_valid && (q.size() != DEPTH) && !flush && !rst;
    inw.c = in_is_coeff;
    inw.d = in_data;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (age == 0) begin
        if (q.size() != 0 && !mw) begin
          w   = q.pop_front();
          cur = w;
          age = 1;
          if (w.c) begin m_coef = w.d; n_coeff_pops++; end
          else     begin m_samp = w.d; n_sample_pops++; end
        end
      end else if (age < 4) begin
        age++;
      end else if (!mw) begin
        age = 0;
        if (flush) begin
          q.delete();
          n_coeff_pops = 0;
        end
      end
      if (push) q.push_back(inw);
    end
    last_push = push;
    armed     = 1'b1;
    #1;
    chk("data_ready", data_ready, (age == 1 || age == 2) && !cur.c);
    chk("load_coeff", load_coeff, (age == 1 || age == 2) && cur.c);
    chk("sample_data", sample_data, m_samp);
    chk("fir_coefficient", fir_coefficient, m_coef);
    chk("coeff_idx", coeff_idx, n_coeff_pops % 4);
    chk("sample_cnt", sample_cnt, n_sample_pops % 65536);
    chk("fifo_count", fifo_count, q.size());
  endtask

  task automatic push_word(input bit c, input logic [15:0] d);
    int n = 0;
    in_valid    = 1'b1;
    in_is_coeff = c;
    in_data     = d;
    do begin
      tick();
      n++;
    end while (!last_push && n < 50);
    in_valid = 1'b0;
    chk("push_accept", last_push, 1);
  endtask

  task automatic wait_age(input int target);
    int n = 0;
    while (age != target && n < 100) begin
      tick();
      n++;
    end
    chk("reach_phase", age, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(age == 0 && q.size() == 0) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", (age == 0 && q.size() == 0), 1);
  endtask

  initial begin
    n_reset     = 1'b0;
    in_valid    = 1'b0;
    in_is_coeff = 1'b0;
    in_data     = 16'h0;
    modwait     = 1'b0;
    err         = 1'b0;
    model_reset();

    // Reset state.
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);

    // Four coefficients in order; coeff_idx wraps back to 0.
    for (int i = 1; i <= 4; i++) push_word(1'b1, 16'(i));
    wait_idle();
    chk("coeff_idx_wrap", coeff_idx, 0);
    chk("last_coeff", fir_coefficient, 16'h0004);

    // modwait held high after GUARD stalls the next issue.
    push_word(1'b0, 16'h0100);
    push_word(1'b0, 16'h0101);
    wait_age(3);
    modwait = 1'b1;
    repeat (10) tick();
    modwait = 1'b0;
    wait_idle();

    // Six back-to-back samples with modwait high: only DEPTH are accepted.
    modwait = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      in_is_coeff = 1'b0;
      in_data     = 16'h0200 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", fifo_count, 4);
    chk("full_not_ready", in_ready, 0);
    modwait = 1'b0;
    tick();
    chk("ready_after_pop", in_ready, 1);
    wait_idle();

    // Interleaved sample/coefficient/sample after a fresh reset.
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    push_word(1'b0, 16'h00AA);
    push_word(1'b1, 16'h0005);
    push_word(1'b0, 16'h00BB);
    wait_idle();
    chk("mix_sample_cnt", sample_cnt, 2);
    chk("mix_sample_data", sample_data, 16'h00BB);
    chk("mix_coeff", fir_coefficient, 16'h0005);

    // Reset during PULSE1 discards the in-flight word and the queue.
    modwait = 1'b1;
    push_word(1'b0, 16'h0011);
    push_word(1'b1, 16'h0012);
    push_word(1'b0, 16'h0013);
    modwait = 1'b0;
    wait_age(1);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    chk("rstmid_dr", data_ready, 0);
    chk("rstmid_lc", load_coeff, 0);
    chk("rstmid_count", fifo_count, 0);
    chk("rstmid_ready", in_ready, 1);
    repeat (3) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_is_coeff = 1'($urandom_range(0, 1));
      in_data     = 16'($urandom);
      modwait     = ($urandom_range(0, 3) == 0);
      err         = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0;
    modwait  = 1'b0;
    err      = 1'b0;
    wait_idle();

    // Error in WAIT_DONE with three words queued and a push in the same cycle.
    push_word(1'b0, 16'h0300);
    wait_age(3);
    modwait = 1'b1;
    push_word(1'b1, 16'h0006);
    push_word(1'b0, 16'h0301);
    push_word(1'b1, 16'h0007);
    chk("queued_three", fifo_count, 3);
    err         = 1'b1;
    modwait     = 1'b0;
    in_valid    = 1'b1;
    in_is_coeff = 1'b0;
    in_data     = 16'h0999;
    tick();
    in_valid = 1'b0;
    err      = 1'b0;
`ifdef FEEDER_FLUSH_ON_ERR_EN
    chk("flush_count", fifo_count, 0);
    chk("flush_coeff_idx", coeff_idx, 0);
`endif
    repeat (10) tick();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
